// File: rtl/register_file_banked_pkg.sv
// Shared types and constants for the banked register file and its clear sequencer.
package register_file_banked_pkg;

  localparam int MAX_HARTS  = 4;
  localparam int MAX_HART_W = 2;

  typedef logic [MAX_HART_W-1:0] hart_id_t;
  typedef logic [4:0]            rs_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ALL,
    CLEAR_ONE
  } regfile_clear_state_t;

  localparam rs_addr_t REGFILE_LAST_IDX = 5'd31;

  // Bank select width; a single bank still gets a 1-bit select so ports never collapse.
  function automatic int hart_width(input int num_harts);
    return (num_harts > 1) ? $clog2(num_harts) : 1;
  endfunction

endpackage

// File: rtl/register_file_banked_clear_seq.sv
// Clear sequencer: zeroes every bank after reset, or one bank on request,
// one register per cycle, and owns the per-bank ready flags.
module regfile_clear_sequencer
  import register_file_banked_pkg::*;
#(
  parameter  int NUM_HARTS = 2,
  localparam int HART_W    = hart_width(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  input  logic [HART_W-1:0]    clear_hart,
  output logic [NUM_HARTS-1:0] bank_ready,
  output logic                 clear_en,
  output rs_addr_t             clear_idx,
  output logic [NUM_HARTS-1:0] clear_mask,
  output logic [NUM_HARTS-1:0] clear_start
);

  regfile_clear_state_t state, state_next;
  rs_addr_t             idx, idx_next;
  logic [HART_W-1:0]    tgt, tgt_next;
  logic [NUM_HARTS-1:0] ready_next;
  logic [NUM_HARTS-1:0] req_onehot;
  logic [NUM_HARTS-1:0] tgt_onehot;
  logic                 req_hart_ok;

  assign req_hart_ok = 32'(clear_hart) < NUM_HARTS;
  assign req_onehot  = NUM_HARTS'(1) << clear_hart;
  assign tgt_onehot  = NUM_HARTS'(1) << tgt;

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    tgt_next    = tgt;
    ready_next  = bank_ready;
    clear_en    = 1'b0;
    clear_mask  = '0;
    clear_start = '0;
    clear_idx   = idx;
    case (state)
      IDLE: begin
        // Requests for a nonexistent bank are dropped; busy-time requests never reach here.
        if (clear_req && req_hart_ok) begin
          state_next  = CLEAR_ONE;
          tgt_next    = clear_hart;
          idx_next    = 5'd1;
          clear_start = req_onehot;
          ready_next  = bank_ready & ~req_onehot;
        end
      end
      CLEAR_ALL: begin
        clear_en   = 1'b1;
        clear_mask = '1;
        idx_next   = idx + 5'd1;
        if (idx == REGFILE_LAST_IDX) begin
          state_next = IDLE;
          ready_next = '1;
        end
      end
      CLEAR_ONE: begin
        clear_en   = 1'b1;
        clear_mask = tgt_onehot;
        idx_next   = idx + 5'd1;
        if (idx == REGFILE_LAST_IDX) begin
          state_next = IDLE;
          ready_next = bank_ready | tgt_onehot;
        end
      end
      default: state_next = CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR_ALL;
      idx        <= 5'd1;
      tgt        <= '0;
      bank_ready <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      tgt        <= tgt_next;
      bank_ready <= ready_next;
    end
  end

endmodule

// File: rtl/register_file_banked.sv
// Banked multi-port register file: one 31-entry bank per hart (x0 hard-wired to zero),
// prioritised commit ports, optional same-cycle bypass and a self-clearing sequencer.
module register_file_banked
  import register_file_banked_pkg::*;
#(
  parameter  int XLEN            = 32,
  parameter  int NUM_HARTS       = 2,
  parameter  int NUM_READ_PORTS  = 2,
  parameter  int NUM_WRITE_PORTS = 2,
  parameter  int BYPASS          = 1,
  localparam int HART_W          = hart_width(NUM_HARTS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_WRITE_PORTS-1:0]             wr_en,
  input  logic [NUM_WRITE_PORTS-1:0][HART_W-1:0] wr_hart,
  input  logic [NUM_WRITE_PORTS-1:0][4:0]        wr_addr,
  input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]   wr_data,
  input  logic [NUM_READ_PORTS-1:0][HART_W-1:0]  rd_hart,
  input  logic [NUM_READ_PORTS-1:0][4:0]         rs_addr,
  output logic [NUM_READ_PORTS-1:0][XLEN-1:0]    rs_data,
  input  logic                                   clear_req,
  input  logic [HART_W-1:0]                      clear_hart,
  output logic [NUM_HARTS-1:0]                   bank_ready,
  output logic                                   x0_write_err
);

  logic [XLEN-1:0]            mem [NUM_HARTS][1:REGFILE_LAST_IDX];
  logic                       clear_en;
  rs_addr_t                   clear_idx;
  logic [NUM_HARTS-1:0]       clear_mask;
  logic [NUM_HARTS-1:0]       clear_start;
  logic [NUM_WRITE_PORTS-1:0] wr_valid;
  logic                       x0_attempt;

  regfile_clear_sequencer #(
    .NUM_HARTS (NUM_HARTS)
  ) u_clear_seq (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .clear_hart  (clear_hart),
    .bank_ready  (bank_ready),
    .clear_en    (clear_en),
    .clear_idx   (clear_idx),
    .clear_mask  (clear_mask),
    .clear_start (clear_start)
  );

  // A bank that is starting a clear this cycle already refuses writes.
  always_comb begin
    wr_valid   = '0;
    x0_attempt = 1'b0;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (wr_en[p] && wr_addr[p] == 5'd0) begin
        x0_attempt = 1'b1;
      end
      if (wr_en[p] && wr_addr[p] != 5'd0 && 32'(wr_hart[p]) < NUM_HARTS) begin
        wr_valid[p] = bank_ready[wr_hart[p]] && !clear_start[wr_hart[p]];
      end
    end
  end

  // Later assignments win: higher write ports over lower ones, and the clear over any write.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (wr_valid[p]) begin
        mem[wr_hart[p]][wr_addr[p]] <= wr_data[p];
      end
    end
    if (clear_en) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (clear_mask[h]) begin
          mem[h][clear_idx] <= '0;
        end
      end
    end
  end

  always_comb begin
    rs_data = '0;
    for (int q = 0; q < NUM_READ_PORTS; q++) begin
      if (rs_addr[q] != 5'd0 && 32'(rd_hart[q]) < NUM_HARTS && bank_ready[rd_hart[q]]) begin
        rs_data[q] = mem[rd_hart[q]][rs_addr[q]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (wr_valid[p] && wr_hart[p] == rd_hart[q] && wr_addr[p] == rs_addr[q]) begin
              rs_data[q] = wr_data[p];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_write_err <= 1'b0;
    end else begin
      x0_write_err <= x0_attempt;
    end
  end

  x0_write_flagged: assert property (@(posedge clk) disable iff (rst) x0_attempt |=> x0_write_err);

endmodule

// File: doc/register_file_banked.md
Name: register_file_banked

Overview:
- Parametrised successor register file for the dual-core build: one architectural register bank per hart, multiple write ports, optional same-cycle write-to-read bypass.
- Self-clearing: a sequencer zeroes every bank after reset, and zeroes a single hart's bank on request.
- Sits between issue (read ports) and writeback/commit (write ports) of each core, or is shared by both cores.

Parameters:
- XLEN, 32, register width in bits.
- NUM_HARTS, 2, number of banks (1..4).
- NUM_READ_PORTS, 2, combinational read ports.
- NUM_WRITE_PORTS, 2, commit ports.
- BYPASS, 1, 1 = a read returns same-cycle committed data; 0 = read returns stored value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  NUM_WRITE_PORTS  per-port commit strobe.
- wr_hart  in  NUM_WRITE_PORTS x HART_W  target bank; HART_W = max(1, $clog2(NUM_HARTS)).
- wr_addr  in  NUM_WRITE_PORTS x 5  destination register.
- wr_data  in  NUM_WRITE_PORTS x XLEN  write data.
- rd_hart  in  NUM_READ_PORTS x HART_W  source bank.
- rs_addr  in  NUM_READ_PORTS x 5  source register.
- rs_data  out  NUM_READ_PORTS x XLEN  read data.
- clear_req  in  1  request zeroing of one bank.
- clear_hart  in  HART_W  bank to clear.
- bank_ready  out  NUM_HARTS  bank usable.
- x0_write_err  out  1  one-cycle pulse on an attempted write to x0.

Behaviour:
- Storage: NUM_HARTS x 31 x XLEN flops. x0 is not stored; any read of x0 returns 0.
- Sequencer states (one shared FSM):
  - IDLE: no clear in progress.
  - CLEAR_ALL: entered from reset.
  - CLEAR_ONE: entered from a clear request.
- Registers: 5-bit index idx and target bank tgt.
- Reset (rst=1 at a clk edge):
  - state <= CLEAR_ALL, idx <= 1.
  - bank_ready <= '0, x0_write_err <= 0.
  - Storage is not reset directly.
- CLEAR_ALL: each cycle writes 0 to register idx of every bank and increments idx. In the cycle idx==31, state <= IDLE and bank_ready <= all ones. Total 31 cycles after reset deasserts.
- IDLE with clear_req=1:
  - state <= CLEAR_ONE, tgt <= clear_hart, idx <= 1, bank_ready[clear_hart] <= 0 on the same edge.
  - CLEAR_ONE zeroes bank tgt only, one register per cycle.
  - At idx==31: state <= IDLE, bank_ready[tgt] <= 1.
  - clear_req while not IDLE is ignored, not queued.
- Writes:
  - Port p writes on a clk edge when wr_en[p], wr_addr[p]!=0 and bank_ready[wr_hart[p]]. Data is visible in storage from the next cycle.
  - Writes to a bank whose bank_ready=0 are silently dropped, including the cycle bank_ready falls.
  - Clear beats write to the same bank in the same cycle.
  - Write-port conflict (same hart and addr): the highest-indexed port wins, for both storage and bypass.
- x0_write_err: registered; asserted the cycle after any port has wr_en=1 and wr_addr==0, whatever the bank state. A simulation assertion flags the same event.
- Reads (combinational, zero latency):
  - rs_data = 0 if rs_addr==0 or bank_ready[rd_hart]==0.
  - Otherwise, with BYPASS=1, the data of the highest-indexed valid writer matching (rd_hart, rs_addr) in that cycle.
  - Otherwise the stored value.
- Out-of-range hart index (>= NUM_HARTS): reads return 0, writes and clears are ignored.
- rst asserted mid-clear: restarts CLEAR_ALL from idx=1.

Decomposition:
- Shared package (taiga_types / taiga_config):
  - hart_id_t (HART_W bits).
  - rs_addr_t (reuse the existing type).
  - regfile_clear_state_t enum {IDLE, CLEAR_ALL, CLEAR_ONE}.
  - REGFILE_LAST_IDX = 31.
- Sub-module regfile_clear_sequencer: FSM, idx, tgt and bank_ready; outputs clear_en, clear_idx, clear_mask[NUM_HARTS].
- Top level: storage, write-priority logic, bypass mux.

Test Plan:
- Reset sequencing: hold rst 2 cycles, release. Required: bank_ready=2'b00 for exactly 31 cycles, then 2'b11. Every read of x1..x31 on both harts returns 0 during and after.
- Dual-port write with bypass: hart0 port0 x5=0xDEADBEEF, port1 x6=0x12345678. Required: same-cycle reads return both values; next-cycle reads return both values.
- Write conflict: both ports write hart1 x7, port0=0x1111 and port1=0x2222. Required: same-cycle read and later reads return 0x2222.
- x0 write: wr_en with wr_addr=0, data 0xFFFFFFFF. Required: x0_write_err high for one cycle; x0 reads 0.
- Single-bank clear: fill hart1 x1..x31 with 0xA5A5A5A5, pulse clear_req with hart=1.
  - Required: bank_ready=2'b01 for 31 cycles; hart1 reads return 0; writes to hart1 are dropped; hart0 writes and reads are unaffected.
  - A second clear_req mid-clear is ignored.
- Reset mid-clear: assert rst at idx=10 of CLEAR_ONE. Required: CLEAR_ALL restarts and bank_ready=2'b00 for 31 cycles.
